// File: rtl/cnn_pkg.sv
// Shared definitions for the conv-layer front end: default widths and the loader state set.
package cnn_pkg;

    localparam int IDX_W      = 16;
    localparam int DATA_SIZE  = 64;
    localparam int NUM_DIGITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        KICK,
        WAIT,
        FIN
    } loader_state_t;

endpackage

// File: rtl/nested_idx_counter.sv
// Four-digit mixed-radix counter with runtime per-digit limits; digit 0 is innermost.
// last is high while every digit sits at its limit, i.e. the next inc wraps everything.
module nested_idx_counter
    import cnn_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           inc,
    input  logic [NUM_DIGITS-1:0][W-1:0]   limit,
    output logic [NUM_DIGITS-1:0][W-1:0]   digit,
    output logic                           last
);

    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] at_lim;

    assign carry[0] = inc;
    assign last     = &at_lim;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [W-1:0] val_reg;
            logic [W-1:0] val_next;

            assign at_lim[gi]   = (val_reg == limit[gi]);
            assign carry[gi+1]  = carry[gi] & at_lim[gi];
            assign digit[gi]    = val_reg;

            // A limit of 0 makes this digit wrap on every carry, so it stays at 0.
            always_comb begin
                val_next = val_reg;
                if (clr) begin
                    val_next = '0;
                end else if (carry[gi]) begin
                    val_next = at_lim[gi] ? '0 : val_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= '0;
                end else begin
                    val_reg <= val_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/layer_loader.sv
// Streams host words into a conv layer as indexed weight writes then activation writes,
// kicks the computation and waits for the layer to report completion.
module layer_loader
    import cnn_pkg::*;
#(
    parameter int NUM_INPUTS  = 1,
    parameter int INPUT_DIM   = 5,
    parameter int NUM_OUTPUTS = 1,
    parameter int KERNEL_DIM  = 3,
    parameter int DATA_SIZE   = cnn_pkg::DATA_SIZE,
    parameter int IDX_W       = cnn_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [DATA_SIZE-1:0] write_data,
    output logic                 want_write_weights,
    output logic                 want_write_act,
    output logic [IDX_W-1:0]     in_index3,
    output logic [IDX_W-1:0]     in_index2,
    output logic [IDX_W-1:0]     in_index1,
    output logic [IDX_W-1:0]     in_index0,
    output logic                 compute,
    input  logic                 layer_done,
    output logic                 busy,
    output logic                 done
);

    generate
        if (NUM_INPUTS < 1 || INPUT_DIM < 1 || NUM_OUTPUTS < 1 || KERNEL_DIM < 1) begin : g_param_check
            $error("layer_loader: NUM_INPUTS, INPUT_DIM, NUM_OUTPUTS and KERNEL_DIM must all be >= 1");
        end
    endgenerate

    // Digit order {index3, index2, index1, index0}; limits are the last valid value of each digit.
    localparam logic [NUM_DIGITS-1:0][IDX_W-1:0] W_LIMIT = {
        IDX_W'(NUM_INPUTS - 1), IDX_W'(NUM_OUTPUTS - 1), IDX_W'(KERNEL_DIM - 1), IDX_W'(KERNEL_DIM - 1)
    };
    localparam logic [NUM_DIGITS-1:0][IDX_W-1:0] A_LIMIT = {
        IDX_W'(0), IDX_W'(NUM_INPUTS - 1), IDX_W'(INPUT_DIM - 1), IDX_W'(INPUT_DIM - 1)
    };

    loader_state_t state_reg, state_next;

    logic                               is_w;
    logic                               is_a;
    logic                               hs;
    logic                               cnt_clr;
    logic                               cnt_last;
    logic [NUM_DIGITS-1:0][IDX_W-1:0]   cnt_limit;
    logic [NUM_DIGITS-1:0][IDX_W-1:0]   cnt_digit;

    logic [DATA_SIZE-1:0] write_data_reg;
    logic                 want_w_reg;
    logic                 want_a_reg;
    logic [IDX_W-1:0]     idx3_reg;
    logic [IDX_W-1:0]     idx2_reg;
    logic [IDX_W-1:0]     idx1_reg;
    logic [IDX_W-1:0]     idx0_reg;

    assign is_w      = (state_reg == LOAD_W);
    assign is_a      = (state_reg == LOAD_A);
    assign hs        = in_valid & in_ready;
    assign cnt_limit = is_w ? W_LIMIT : A_LIMIT;

    nested_idx_counter #(
        .W(IDX_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (hs),
        .limit (cnt_limit),
        .digit (cnt_digit),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Clearing on the last weight beat lets the first activation beat follow with no gap.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        in_ready   = 1'b0;
        compute    = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD_W;
                    cnt_clr    = 1'b1;
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last) begin
                    state_next = LOAD_A;
                    cnt_clr    = 1'b1;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last) begin
                    state_next = KICK;
                end
            end
            KICK: begin
                compute    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (layer_done) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_data_reg <= '0;
            want_w_reg     <= 1'b0;
            want_a_reg     <= 1'b0;
            idx3_reg       <= '0;
            idx2_reg       <= '0;
            idx1_reg       <= '0;
            idx0_reg       <= '0;
        end else begin
            want_w_reg <= hs & is_w;
            want_a_reg <= hs & is_a;
            if (hs) begin
                write_data_reg <= in_data;
                idx3_reg       <= is_w ? cnt_digit[3] : '0;
                idx2_reg       <= cnt_digit[2];
                idx1_reg       <= cnt_digit[1];
                idx0_reg       <= cnt_digit[0];
            end
        end
    end

    assign write_data         = write_data_reg;
    assign want_write_weights = want_w_reg;
    assign want_write_act     = want_a_reg;
    assign in_index3          = idx3_reg;
    assign in_index2          = idx2_reg;
    assign in_index1          = idx1_reg;
    assign in_index0          = idx0_reg;

endmodule

// File: tb/tb_layer_loader.sv
// Bench for layer_loader: a default instance and a 2-input/3-output instance driven from a
// table of runs, each checked beat by beat against an index list built with nested loops.
module tb_layer_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s      [2];
    logic        start_s      [2];
    logic        in_valid_s   [2];
    logic [63:0] in_data_s    [2];
    logic        layer_done_s [2];
    logic        in_ready_s   [2];
    logic [63:0] wd_s         [2];
    logic        ww_s         [2];
    logic        wa_s         [2];
    logic [15:0] i3_s         [2];
    logic [15:0] i2_s         [2];
    logic [15:0] i1_s         [2];
    logic [15:0] i0_s         [2];
    logic        compute_s    [2];
    logic        busy_s       [2];
    logic        done_s       [2];

    layer_loader dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .write_data(wd_s[0]), .want_write_weights(ww_s[0]), .want_write_act(wa_s[0]),
        .in_index3(i3_s[0]), .in_index2(i2_s[0]), .in_index1(i1_s[0]), .in_index0(i0_s[0]),
        .compute(compute_s[0]), .layer_done(layer_done_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    layer_loader #(.NUM_INPUTS(2), .NUM_OUTPUTS(3)) dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .write_data(wd_s[1]), .want_write_weights(ww_s[1]), .want_write_act(wa_s[1]),
        .in_index3(i3_s[1]), .in_index2(i2_s[1]), .in_index1(i1_s[1]), .in_index0(i0_s[1]),
        .compute(compute_s[1]), .layer_done(layer_done_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int w;
        int i3;
        int i2;
        int i1;
        int i0;
    } exp_t;

    typedef struct {
        int sel;
        int gap;
        int directed;
        int wait_cyc;
        int abort_at;
        int start_mid;
        int exp_w;
        int exp_a;
        int exp_c;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_zero(input int s, input string tag);
        chk({tag, "_write_data"}, wd_s[s], 0);
        chk({tag, "_want_w"}, 64'(ww_s[s]), 0);
        chk({tag, "_want_a"}, 64'(wa_s[s]), 0);
        chk({tag, "_idx"}, {i3_s[s], i2_s[s], i1_s[s], i0_s[s]}, 0);
        chk({tag, "_ready"}, 64'(in_ready_s[s]), 0);
        chk({tag, "_compute"}, 64'(compute_s[s]), 0);
        chk({tag, "_busy"}, 64'(busy_s[s]), 0);
        chk({tag, "_done"}, 64'(done_s[s]), 0);
    endtask

    task automatic run_vec(input vec_t v, output int n_w, output int n_a, output int n_c);
        int s = v.sel;
        int ni = (s == 0) ? 1 : 2;
        int no = (s == 0) ? 1 : 3;
        int kd = 3;
        int id = 5;
        int total;
        int nw_total;
        int nsent = 0;
        int nseen = 0;
        bit hs_prev = 1'b0;
        bit got_c = 1'b0;
        exp_t q[$];
        logic [63:0] dat[$];

        n_w = 0;
        n_a = 0;
        n_c = 0;
        for (int a = 0; a < ni; a++)
            for (int b = 0; b < no; b++)
                for (int y = 0; y < kd; y++)
                    for (int x = 0; x < kd; x++)
                        q.push_back('{1, a, b, y, x});
        nw_total = q.size();
        for (int e = 0; e < ni; e++)
            for (int y = 0; y < id; y++)
                for (int x = 0; x < id; x++)
                    q.push_back('{0, 0, e, y, x});
        total = q.size();
        for (int k = 0; k <= total; k++)
            dat.push_back(v.directed != 0 ? $realtobits(real'(k + 1)) : {$urandom, $urandom});

        @(negedge clk);
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;

        for (int cyc = 0; cyc < total * 20 + 50; cyc++) begin
            chk("strobe_follows_handshake", 64'(ww_s[s] | wa_s[s]), 64'(hs_prev));
            if (ww_s[s] || wa_s[s]) begin
                if (nseen >= total) begin
                    chk("extra_strobe", 1, 0);
                end else begin
                    chk("kind_is_weight", 64'(ww_s[s]), 64'(q[nseen].w));
                    chk("index3", 64'(i3_s[s]), 64'(q[nseen].i3));
                    chk("index2", 64'(i2_s[s]), 64'(q[nseen].i2));
                    chk("index1", 64'(i1_s[s]), 64'(q[nseen].i1));
                    chk("index0", 64'(i0_s[s]), 64'(q[nseen].i0));
                    chk("write_data", wd_s[s], dat[nseen]);
                end
                if (ww_s[s]) n_w++;
                if (wa_s[s]) n_a++;
                nseen++;
            end
            chk("compute", 64'(compute_s[s]), 64'(hs_prev && nseen == total));
            if (compute_s[s]) begin
                got_c = 1'b1;
                n_c++;
                break;
            end
            chk("in_ready", 64'(in_ready_s[s]), 64'(nsent < total));
            chk("busy_loading", 64'(busy_s[s]), 1);

            if (v.abort_at > 0 && nsent == v.abort_at) begin
                rst_n_s[s] = 1'b0;
                #1;
                check_zero(s, "abort");
                in_valid_s[s] = 1'b0;
                @(negedge clk);
                rst_n_s[s] = 1'b1;
                @(negedge clk);
                return;
            end

            start_s[s] = (v.start_mid != 0 && nseen >= nw_total + 3 && nseen < nw_total + 6);
            in_valid_s[s] = (v.gap == 0) ? 1'b1 : ($urandom_range(99) >= v.gap);
            in_data_s[s]  = dat[nsent];
            hs_prev = in_valid_s[s] && (nsent < total);
            if (hs_prev) nsent++;
            @(negedge clk);
        end
        start_s[s] = 1'b0;

        if (!got_c) begin
            chk("compute_timeout", 0, 1);
            rst_n_s[s] = 1'b0;
            in_valid_s[s] = 1'b0;
            @(negedge clk);
            rst_n_s[s] = 1'b1;
            @(negedge clk);
            return;
        end

        // layer_done raised during KICK must not end the wait.
        in_valid_s[s]   = 1'b1;
        layer_done_s[s] = 1'b1;
        @(negedge clk);
        layer_done_s[s] = 1'b0;
        for (int w = 0; w < v.wait_cyc; w++) begin
            chk("wait_busy", 64'(busy_s[s]), 1);
            chk("wait_ready", 64'(in_ready_s[s]), 0);
            chk("wait_done", 64'(done_s[s]), 0);
            chk("wait_compute", 64'(compute_s[s]), 0);
            chk("wait_strobe", 64'(ww_s[s] | wa_s[s]), 0);
            @(negedge clk);
        end
        layer_done_s[s] = 1'b1;
        @(negedge clk);
        layer_done_s[s] = 1'b0;
        chk("fin_done", 64'(done_s[s]), 1);
        chk("fin_busy", 64'(busy_s[s]), 1);
        @(negedge clk);
        chk("idle_done", 64'(done_s[s]), 0);
        chk("idle_busy", 64'(busy_s[s]), 0);
        chk("idle_strobe", 64'(ww_s[s] | wa_s[s]), 0);
        in_valid_s[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[10];
        int nw;
        int na;
        int nc;

        for (int s = 0; s < 2; s++) begin
            rst_n_s[s]      = 1'b0;
            start_s[s]      = 1'b0;
            in_valid_s[s]   = 1'b0;
            in_data_s[s]    = '0;
            layer_done_s[s] = 1'b0;
        end

        //          sel gap dir wait abort smid  w   a  c
        tbl[0] = '{0,   0,  1,  3,   0,   0,    9, 25, 1};
        tbl[1] = '{0,  50,  0,  2,   0,   0,    9, 25, 1};
        tbl[2] = '{1,   0,  0,  2,   0,   0,   54, 50, 1};
        tbl[3] = '{1,  50,  0,  2,   0,   0,   54, 50, 1};
        tbl[4] = '{0,   0,  1, 100,  0,   0,    9, 25, 1};
        tbl[5] = '{0,   0,  1,  2,   4,   0,    4,  0, 0};
        tbl[6] = '{0,   0,  1,  2,   0,   0,    9, 25, 1};
        tbl[7] = '{0,  50,  0,  2,   0,   1,    9, 25, 1};
        tbl[8] = '{1,  30,  0,  2,   4,   0,    4,  0, 0};
        tbl[9] = '{1,  30,  0,  2,   0,   1,   54, 50, 1};

        repeat (3) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        @(negedge clk);
        check_zero(0, "post_reset0");

        for (int r = 0; r < 10; r++) begin
            run_vec(tbl[r], nw, na, nc);
            chk("weight_beats", 64'(nw), 64'(tbl[r].exp_w));
            chk("act_beats", 64'(na), 64'(tbl[r].exp_a));
            chk("compute_pulses", 64'(nc), 64'(tbl[r].exp_c));
            $display("run %0d dut=%0d gap=%0d abort=%0d weights=%0d acts=%0d computes=%0d",
                     r, tbl[r].sel, tbl[r].gap, tbl[r].abort_at, nw, na, nc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
